// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle at capture; divides always iterate.
module muldiv_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 3,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [OP_WIDTH-1:0]   MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);
  localparam int W = DATA_WIDTH;
  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [COUNT_WIDTH-1:0] cnt;
  logic [OP_WIDTH-1:0]    op_q;
  logic                   sa_q, sb_q;
  // hi/lo: product {hi,lo} for multiply, {remainder,quotient} for divide; m is the addend/divisor
  logic [W-1:0]           hi, lo, m;
  logic [W-1:0]           hi_n, lo_n, res_calc;

  // Apply sign correction and pick the architectural result from an unsigned hi/lo pair
  function automatic logic [W-1:0] sel_result(input logic [OP_WIDTH-1:0] op, input logic sa,
                                              input logic sb, input logic [W-1:0] h,
                                              input logic [W-1:0] l);
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, res;
    prod = {h, l};
    if (sa ^ sb) prod = -prod;
    quo = (sa ^ sb) ? -l : l;
    rem = sa ? -h : h;
    case (op)
      OP_MUL:                      res = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*W-1:W];
      OP_DIV, OP_DIVU:             res = quo;
      default:                     res = rem;
    endcase
    return res;
  endfunction

  logic         is_div_in, sa_in, sb_in, div_zero, div_ovf, special, fast_mul;
  logic [W-1:0] amag_in, bmag_in, spec_res, fast_res;

  assign is_div_in = MulDivOp[2];
  assign sa_in = (MulDivOp == OP_MULH || MulDivOp == OP_MULHSU || MulDivOp == OP_DIV ||
                  MulDivOp == OP_REM) && SrcA[W-1];
  assign sb_in = (MulDivOp == OP_MULH || MulDivOp == OP_DIV || MulDivOp == OP_REM) && SrcB[W-1];
  assign amag_in = sa_in ? -SrcA : SrcA;
  assign bmag_in = sb_in ? -SrcB : SrcB;
  assign div_zero = is_div_in && (SrcB == '0);
  assign div_ovf  = (MulDivOp == OP_DIV || MulDivOp == OP_REM) &&
                    (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
  assign special  = div_zero || div_ovf;
  // MulDivOp[1] distinguishes REM/REMU from DIV/DIVU
  assign spec_res = div_zero ? (MulDivOp[1] ? SrcA : '1) : (MulDivOp[1] ? '0 : SrcA);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, amag_in} * {{W{1'b0}}, bmag_in};
  assign fast_mul  = !is_div_in;
  assign fast_res  = sel_result(MulDivOp, sa_in, sb_in, fast_prod[2*W-1:W], fast_prod[W-1:0]);
`else
  assign fast_mul  = 1'b0;
  assign fast_res  = '0;
`endif

  logic [W:0] sum, sh, diff;
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    sum  = '0;
    sh   = '0;
    diff = '0;
    if (op_q[2]) begin
      sh   = {hi, lo[W-1]};
      diff = sh - {1'b0, m};
      if (!diff[W]) begin
        hi_n = diff[W-1:0];
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = sh[W-1:0];
        lo_n = {lo[W-2:0], 1'b0};
      end
    end else begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      hi_n = sum[W:1];
      lo_n = {sum[0], lo[W-1:1]};
    end
  end

  assign res_calc = sel_result(op_q, sa_q, sb_q, hi_n, lo_n);

  always_comb begin
    state_nxt = state;
    if (Flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (Start) state_nxt = (special || fast_mul) ? DONE : CALC;
        CALC:    if (cnt == COUNT_WIDTH'(W-1)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      Result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Start && !Flush) begin
        op_q <= MulDivOp;
        sa_q <= sa_in;
        sb_q <= sb_in;
        m    <= is_div_in ? bmag_in : amag_in;
        lo   <= is_div_in ? amag_in : bmag_in;
        hi   <= '0;
        cnt  <= '0;
        if (special) Result <= spec_res;
        else if (fast_mul) Result <= fast_res;
      end else if (state == CALC && !Flush) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + COUNT_WIDTH'(1);
        if (cnt == COUNT_WIDTH'(W-1)) Result <= res_calc;
      end
    end
  end

  assign Busy = (state == CALC);
  assign Done = (state == DONE);
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic reference model with per-cycle Busy/Done/Result checks.
module tb_muldiv_seq;
  logic        clk = 1'b0, rst = 1'b1, Start = 1'b0, Flush = 1'b0;
  logic [2:0]  MulDivOp = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        Busy, Done;
  logic [31:0] Result;
  int tests = 0, fails = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .Start(Start), .MulDivOp(MulDivOp), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Busy(Busy), .Done(Done), .Result(Result)
  );

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    logic [31:0] r;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Cycles from the capturing edge until Done is visible (1 = Done right after that edge)
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2])
      return ((b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    return FAST ? 1 : 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge-indexed transaction tracking
  int          m_cyc = 0, m_done_at = 0;
  bit          m_active = 0, m_slow = 0;
  logic [31:0] m_res = '0, m_last = '0;

  always @(posedge clk) begin
    m_cyc <= m_cyc + 1;
    if (rst) begin
      m_active <= 1'b0;
      m_last   <= '0;
    end else if (Flush) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (m_cyc + 1 == m_done_at) m_last <= m_res;
      if (m_cyc + 1 == m_done_at + 1) m_active <= 1'b0;
    end else if (Start) begin
      m_active  <= 1'b1;
      m_done_at <= m_cyc + lat_of(MulDivOp, SrcA, SrcB);
      m_slow    <= lat_of(MulDivOp, SrcA, SrcB) > 1;
      m_res     <= model(MulDivOp, SrcA, SrcB);
      if (lat_of(MulDivOp, SrcA, SrcB) == 1) m_last <= model(MulDivOp, SrcA, SrcB);
    end
  end

  always @(negedge clk) begin
    if (m_cyc > 0) begin
      chk("cyc busy", {31'b0, Busy}, {31'b0, m_active && m_slow && (m_cyc < m_done_at)});
      chk("cyc done", {31'b0, Done}, {31'b0, m_active && (m_cyc == m_done_at)});
      chk("cyc result", Result, m_last);
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n, nbusy, lat;
    lat = lat_of(op, a, b);
    chk({name, " model"}, model(op, a, b), exp);
    @(negedge clk);
    MulDivOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MulDivOp = 3'($urandom);
    n = 1; nbusy = int'(Busy);
    while (!Done && n < 40) begin
      @(negedge clk);
      n++;
      nbusy += int'(Busy);
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " result"}, Result, exp);
    chk({name, " busy cycles"}, 32'(nbusy), (lat == 1) ? 32'd0 : 32'd32);
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      @(negedge clk);
      nd += int'(Done);
    end
  endtask

  initial begin
    int n, nd;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, Busy}, 32'd0);
    chk("reset done", {31'b0, Done}, 32'd0);
    chk("reset result", Result, 32'd0);
    rst = 1'b0;

    run_op("MUL", 3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MULH", 3'd1, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("MULHU", 3'd3, 32'h7, 32'hFFFF_FFFD, 32'h0000_0006);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("MULHU max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
    run_op("REM", 3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
    run_op("DIVU", 3'd5, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC);
    run_op("REMU", 3'd7, 32'd100, 32'd7, 32'd2);
    run_op("DIV negb", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_op("REM nega", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run_op("DIVU by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("REM by0", 3'd6, 32'd5, 32'd0, 32'd5);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Reset in the middle of a DIVU 100/7
    @(negedge clk); MulDivOp = 3'd5; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst busy", {31'b0, Busy}, 32'd0);
    chk("midrst done", {31'b0, Done}, 32'd0);
    chk("midrst result", Result, 32'd0);
    rst = 1'b0;
    count_done(40, nd);
    chk("midrst no done", 32'(nd), 32'd0);

    // Flush at CALC iteration 10; prior result must survive
    run_op("MUL pre", 3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(negedge clk); MulDivOp = 3'd5; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk); Flush = 1'b0;
    chk("flush busy", {31'b0, Busy}, 32'd0);
    count_done(40, nd);
    chk("flush no done", 32'(nd), 32'd0);
    chk("flush result", Result, 32'hFFFF_FFEB);

    // Flush together with Start drops the request
    @(negedge clk); MulDivOp = 3'd5; SrcA = 32'd9; SrcB = 32'd0; Start = 1'b1; Flush = 1'b1;
    @(negedge clk); Start = 1'b0; Flush = 1'b0;
    chk("flush+start done", {31'b0, Done}, 32'd0);
    count_done(5, nd);
    chk("flush+start no done", 32'(nd), 32'd0);

    // Starts during CALC and DONE are ignored
    @(negedge clk); MulDivOp = 3'd5; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    n = 1;
    while (!Done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) begin MulDivOp = 3'd0; SrcA = 32'd3; SrcB = 32'd3; Start = 1'b1; end
      if (n == 6) Start = 1'b0;
    end
    chk("ignore latency", 32'(n), 32'd33);
    chk("ignore result", Result, 32'd14);
    MulDivOp = 3'd5; SrcA = 32'd5; SrcB = 32'd0; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    chk("start in DONE ignored", {31'b0, Done}, 32'd0);
    chk("start in DONE result", Result, 32'd14);
    run_op("REMU after", 3'd7, 32'd5, 32'd0, 32'd5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the main single-cycle ALU, in the execute stage.
- Captures operands on a start pulse and runs a radix-2 shift-add / restoring-divide loop, one bit per cycle.
- Raises Busy so the hazard unit stalls the pipeline.
- Presents the result with a one-cycle Done pulse.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OP_WIDTH, 3, width of MulDivOp (RV32M funct3 encoding).
- COUNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request pulse; sampled only in IDLE.
- MulDivOp  input  OP_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  rs1 operand (dividend / multiplicand).
- SrcB  input  DATA_WIDTH  rs2 operand (divisor / multiplier).
- Flush  input  1  abort the in-flight operation (branch mispredict / trap).
- Busy  output  1  high while state is CALC; drives pipeline stall.
- Done  output  1  one-cycle pulse, high in state DONE.
- Result  output  DATA_WIDTH  final result; valid when Done=1, held until next Done.

Behaviour:
- Reset: state=IDLE, Busy=0, Done=0, Result=0, counter=0, internal accumulators=0. Reset mid-operation discards all work; no Done.
- FSM states and transitions:
  - IDLE: on Start=1, latch SrcA, SrcB, MulDivOp.
    - Special divide case: next state DONE.
    - Otherwise: next state CALC, counter=0.
  - CALC: one iteration per cycle; counter increments. When counter==DATA_WIDTH-1, next state DONE.
  - DONE: Done=1, Result updated this cycle; next state IDLE unconditionally.
- Latency: Start sampled at edge t gives Done high in cycle t+DATA_WIDTH+1 (t+33 at default); special divide cases give Done in cycle t+1. Busy=1 for exactly DATA_WIDTH cycles on the normal path.
- Start while not IDLE: ignored, including during DONE. The issuing stage re-presents Start in IDLE; back-to-back issue costs one idle cycle.
- Signed handling:
  - Signed operands (MULH: both; MULHSU: A only; DIV/REM: both) are converted to magnitude at capture.
  - The unsigned core computes a 2*DATA_WIDTH product or quotient/remainder.
  - Product sign = signA XOR signB. Quotient sign = signA XOR signB. Remainder sign = signA. Negation is applied when entering DONE.
- Result select:
  - MUL: low DATA_WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high DATA_WIDTH bits of the product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Special divide cases (no CALC):
  - SrcB==0: quotient = all ones; remainder = SrcA.
  - DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Flush: any state goes to IDLE next edge. Busy=0 and Done=0 from the next cycle; Result unchanged. Flush in the same cycle as Start in IDLE: Flush wins, request dropped. Flush in DONE: Done still high that cycle (already committed), then IDLE.
- Rst and Flush together: reset behaviour.
- Operands on SrcA/SrcB/MulDivOp may change after capture without effect.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle full-width multiplier at capture and go IDLE→DONE directly. Done arrives in cycle t+1 and Busy never asserts for multiplies. Divides are unchanged.
- MULDIV_FAST_MUL_EN undefined: all ops use the iterative path as specified above.

Test Plan:
- Reset: hold rst 2 cycles mid-CALC of DIVU 100/7 -> Busy=0, Done=0, Result=0; no Done pulse follows.
- MUL: Start with SrcA=0x00000007, SrcB=0xFFFFFFFD (-3), op=000 -> Busy=1 for 32 cycles; Done at t+33; Result=0xFFFFFFEB. MULH same operands -> Result=0xFFFFFFFF. MULHU -> Result=0x00000006.
- Divide: DIV SrcA=-7 (0xFFFFFFF9), SrcB=2 -> Result=0xFFFFFFFD. REM same operands -> Result=0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> Result=0x7FFFFFFC.
- Special cases: DIVU 5/0 -> Done at t+1, Result=0xFFFFFFFF. REM 5/0 -> Result=5. DIV 0x80000000/0xFFFFFFFF -> Result=0x80000000, Busy never high.
- Flush and Start: Flush at CALC iteration 10 -> IDLE next cycle, no Done, Result keeps prior value. Start pulses during CALC/DONE -> ignored; a new Start in IDLE completes normally.
- MULDIV_FAST_MUL_EN: MULHU 0xFFFFFFFF*0xFFFFFFFF -> Done at t+1, Result=0xFFFFFFFE, Busy=0 throughout. Repeat without the macro -> Done at t+33, same Result.
